// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: steps a phase-increment word between p_start and p_stop
// in single, sawtooth or triangle patterns, holding each value for dwell cycles.
`default_nettype none

module freq_sweep_ctrl #(
  parameter int P_W  = 13,
  parameter int DW_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [1:0]      i_mode,
  input  logic [P_W-1:0]  i_p_start,
  input  logic [P_W-1:0]  i_p_stop,
  input  logic [P_W-1:0]  i_p_step,
  input  logic [DW_W-1:0] i_dwell,
  output logic [P_W-1:0]  o_p1,
  output logic            o_busy,
  output logic            o_step_strobe,
  output logic            o_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UP     = 2'd1,
    S_DOWN   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t          r_state, w_state_nx;
  logic [P_W-1:0]  r_p1, w_p1_nx;
  logic [DW_W-1:0] r_cnt, w_cnt_nx;
  logic            r_busy, w_busy_nx;
  logic            r_stb, w_stb_nx;
  logic            r_done, w_done_nx;
  logic            w_accept;

  logic [1:0]      r_mode;
  logic [P_W-1:0]  r_pstart, r_pstop, r_pstep;
  logic [DW_W-1:0] r_dwell;

  logic [DW_W-1:0] w_dwell_in;
  logic [P_W-1:0]  w_pstep_in;
  logic [P_W:0]    w_sum, w_floor;
  logic [P_W-1:0]  w_up_val, w_down_val;
  logic            w_expire, w_degenerate;

  // Zero dwell/step would stall the sweep, so both are promoted to 1.
  assign w_dwell_in   = (i_dwell == '0)  ? DW_W'(1) : i_dwell;
  assign w_pstep_in   = (i_p_step == '0) ? P_W'(1)  : i_p_step;

  assign w_sum        = {1'b0, r_p1} + {1'b0, r_pstep};
  assign w_floor      = {1'b0, r_pstart} + {1'b0, r_pstep};
  assign w_up_val     = (w_sum >= {1'b0, r_pstop}) ? r_pstop : w_sum[P_W-1:0];
  assign w_down_val   = ({1'b0, r_p1} < w_floor) ? r_pstart : (r_p1 - r_pstep);
  assign w_expire     = (r_cnt == DW_W'(1));
  assign w_degenerate = (r_pstop <= r_pstart);

  always_comb begin
    w_state_nx = r_state;
    w_p1_nx    = r_p1;
    w_cnt_nx   = r_cnt;
    w_busy_nx  = r_busy;
    w_stb_nx   = 1'b0;
    w_done_nx  = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_accept   = 1'b1;
          w_state_nx = S_UP;
          w_p1_nx    = i_p_start;
          w_cnt_nx   = w_dwell_in;
          w_busy_nx  = 1'b1;
          w_stb_nx   = 1'b1;
        end
      end
      S_UP: begin
        if (i_abort) begin
          w_state_nx = S_IDLE;
          w_busy_nx  = 1'b0;
        end else if (!w_expire) begin
          w_cnt_nx = r_cnt - DW_W'(1);
        end else if (w_degenerate || (r_p1 == r_pstop && r_mode == 2'b00)) begin
          w_state_nx = S_FINISH;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
        end else begin
          w_cnt_nx = r_dwell;
          w_stb_nx = 1'b1;
          if (r_p1 == r_pstop) begin
            if (r_mode == 2'b01) begin
              w_p1_nx = r_pstart;
            end else begin
              w_state_nx = S_DOWN;
              w_p1_nx    = w_down_val;
            end
          end else begin
            w_p1_nx = w_up_val;
          end
        end
      end
      S_DOWN: begin
        if (i_abort) begin
          w_state_nx = S_IDLE;
          w_busy_nx  = 1'b0;
        end else if (!w_expire) begin
          w_cnt_nx = r_cnt - DW_W'(1);
        end else begin
          w_cnt_nx = r_dwell;
          w_stb_nx = 1'b1;
          if (r_p1 == r_pstart) begin
            w_state_nx = S_UP;
            w_p1_nx    = w_up_val;
          end else begin
            w_p1_nx = w_down_val;
          end
        end
      end
      S_FINISH: begin
        w_state_nx = S_IDLE;
        w_busy_nx  = 1'b0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_p1    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_stb   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_p1    <= w_p1_nx;
      r_cnt   <= w_cnt_nx;
      r_busy  <= w_busy_nx;
      r_stb   <= w_stb_nx;
      r_done  <= w_done_nx;
    end
  end

  // Mode 11 is folded into single mode at latch time.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode   <= 2'b00;
      r_pstart <= '0;
      r_pstop  <= '0;
      r_pstep  <= '0;
      r_dwell  <= '0;
    end else if (w_accept) begin
      r_mode   <= (i_mode == 2'b11) ? 2'b00 : i_mode;
      r_pstart <= i_p_start;
      r_pstop  <= i_p_stop;
      r_pstep  <= w_pstep_in;
      r_dwell  <= w_dwell_in;
    end
  end

  assign o_p1          = r_p1;
  assign o_busy        = r_busy;
  assign o_step_strobe = r_stb;
  assign o_done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_freq_sweep_ctrl.sv
// Directed, table-driven bench for freq_sweep_ctrl.
`default_nettype none

module tb_freq_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [1:0]  mode;
  logic [12:0] p_start, p_stop, p_step;
  logic [15:0] dwell;
  logic [12:0] p1;
  logic        busy, stb, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        start;
    logic        abort;
    logic [12:0] p1;
    logic        busy;
    logic        stb;
    logic        done;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  freq_sweep_ctrl #(.P_W(13), .DW_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_mode(mode), .i_p_start(p_start), .i_p_stop(p_stop), .i_p_step(p_step),
    .i_dwell(dwell), .o_p1(p1), .o_busy(busy), .o_step_strobe(stb), .o_done(done)
  );

  task automatic chk(input string name, input int idx, input logic [12:0] e_p1,
                     input logic e_busy, input logic e_stb, input logic e_done);
    total++;
    if (p1 !== e_p1 || busy !== e_busy || stb !== e_stb || done !== e_done) begin
      bad++;
      $display("FAIL %s[%0d]: got p1=%0d busy=%b stb=%b done=%b, want p1=%0d busy=%b stb=%b done=%b",
               name, idx, p1, busy, stb, done, e_p1, e_busy, e_stb, e_done);
    end
  endtask

  task automatic push(input logic s, input logic a, input int p, input logic b,
                      input logic st, input logic d);
    vec_t v;
    v.start = s; v.abort = a; v.p1 = p[12:0]; v.busy = b; v.stb = st; v.done = d;
    vq.push_back(v);
  endtask

  task automatic cfg(input logic [1:0] m, input int ps, input int pe, input int st, input int dw);
    mode = m; p_start = ps[12:0]; p_stop = pe[12:0]; p_step = st[12:0]; dwell = dw[15:0];
  endtask

  // Record k drives inputs during cycle k; its expectation is the state at cycle k+1.
  // With scramble set, config inputs change right after the start edge to prove they were latched.
  task automatic run_vecs(input string name, input bit scramble);
    for (int k = 0; k < vq.size(); k++) begin
      start = vq[k].start;
      abort = vq[k].abort;
      @(posedge clk); #1;
      if (k == 0 && scramble) begin
        mode = ~mode; p_start = 13'd1000; p_stop = 13'd2; p_step = 13'd7; dwell = 16'd9;
      end
      chk(name, k, vq[k].p1, vq[k].busy, vq[k].stb, vq[k].done);
    end
    start = 1'b0;
    abort = 1'b0;
    vq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg(2'b00, 0, 0, 0, 0);
    #2;
    chk("reset", 0, 13'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", 0, 13'd0, 1'b0, 1'b0, 1'b0);

    // Single sweep 13..88 step 25 dwell 4; a start while busy is ignored.
    cfg(2'b00, 13, 88, 25, 4);
    push(1,0,13,1,1,0); push(0,0,13,1,0,0); push(0,0,13,1,0,0); push(0,0,13,1,0,0);
    push(0,0,38,1,1,0); push(0,0,38,1,0,0); push(1,0,38,1,0,0); push(0,0,38,1,0,0);
    push(0,0,63,1,1,0); push(0,0,63,1,0,0); push(0,0,63,1,0,0); push(0,0,63,1,0,0);
    push(0,0,88,1,1,0); push(0,0,88,1,0,0); push(0,0,88,1,0,0); push(0,0,88,1,0,0);
    push(0,0,88,0,0,1); push(0,0,88,0,0,0); push(0,0,88,0,0,0);
    run_vecs("single", 1'b1);

    // Abort at p1=38, restart one cycle later, then abort+start together in IDLE.
    cfg(2'b00, 13, 88, 25, 4);
    push(1,0,13,1,1,0); push(0,0,13,1,0,0); push(0,0,13,1,0,0); push(0,0,13,1,0,0);
    push(0,0,38,1,1,0); push(0,1,38,0,0,0); push(1,0,13,1,1,0); push(0,0,13,1,0,0);
    push(0,1,13,0,0,0); push(1,1,13,0,0,0); push(0,0,13,0,0,0);
    run_vecs("abort", 1'b0);

    // Sawtooth with clamp to 50, abort landing on a dwell-expiry edge.
    cfg(2'b01, 13, 50, 25, 2);
    push(1,0,13,1,1,0); push(0,0,13,1,0,0); push(0,0,38,1,1,0); push(0,0,38,1,0,0);
    push(0,0,50,1,1,0); push(0,0,50,1,0,0); push(0,0,13,1,1,0); push(0,0,13,1,0,0);
    push(0,0,38,1,1,0); push(0,0,38,1,0,0); push(0,1,38,0,0,0); push(0,0,38,0,0,0);
    run_vecs("sawtooth", 1'b1);

    // Triangle: 13,38,50,25,13,38,50,25.
    cfg(2'b10, 13, 50, 25, 2);
    push(1,0,13,1,1,0); push(0,0,13,1,0,0); push(0,0,38,1,1,0); push(0,0,38,1,0,0);
    push(0,0,50,1,1,0); push(0,0,50,1,0,0); push(0,0,25,1,1,0); push(0,0,25,1,0,0);
    push(0,0,13,1,1,0); push(0,0,13,1,0,0); push(0,0,38,1,1,0); push(0,0,38,1,0,0);
    push(0,0,50,1,1,0); push(0,0,50,1,0,0); push(0,0,25,1,1,0); push(0,0,25,1,0,0);
    push(0,1,25,0,0,0);
    run_vecs("triangle", 1'b1);

    // p_stop == p_start with dwell 0 in sawtooth mode still finishes after one cycle.
    cfg(2'b01, 47, 47, 25, 0);
    push(1,0,47,1,1,0); push(0,0,47,0,0,1); push(0,0,47,0,0,0);
    run_vecs("degenerate", 1'b1);

    // Zero step becomes 1; mode 11 behaves as single.
    cfg(2'b11, 10, 12, 0, 1);
    push(1,0,10,1,1,0); push(0,0,11,1,1,0); push(0,0,12,1,1,0);
    push(0,0,12,0,0,1); push(0,0,12,0,0,0);
    run_vecs("step_zero", 1'b1);

    // Asynchronous reset mid-sweep.
    cfg(2'b00, 13, 88, 25, 4);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset", 0, 13'd38, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 0, 13'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_reset_idle", k, 13'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/freq_sweep_ctrl.md
FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 Parameter: P_W, default 13, width of the phase-increment word driven to the downstream sine generator.
REQ-002 Parameter: DW_W, default 16, width of the dwell counter.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 resets immediately, release is synchronous to clock.
REQ-005 start  input  1  begin a sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate the sweep; sampled in every state.
REQ-007 mode  input  2  00 single, 01 sawtooth repeat, 10 triangle repeat, 11 treated as 00.
REQ-008 p_start  input  P_W  first phase increment.
REQ-009 p_stop  input  P_W  final phase increment.
REQ-010 p_step  input  P_W  increment added or subtracted per step.
REQ-011 dwell  input  DW_W  clock cycles each p1 value is held.
REQ-012 p1  output  P_W  phase increment driven directly to the sine generator's p1 input; registered.
REQ-013 busy  output  1  high while a sweep is active.
REQ-014 step_strobe  output  1  one-cycle pulse in the first cycle of each new p1 value.
REQ-015 done  output  1  one-cycle pulse when a single-mode sweep completes.

Function
REQ-016 States: IDLE, UP, DOWN, FINISH; all outputs are registered.
REQ-017 In IDLE, start=1 with abort=0 latches mode, p_start, p_stop, p_step and dwell into internal registers; later input changes are ignored until the next start.
REQ-018 In the cycle after start is accepted: p1=p_start, busy=1, step_strobe=1, state=UP, dwell counter loaded.
REQ-019 A latched dwell of 0 is treated as 1; a latched p_step of 0 is treated as 1.
REQ-020 Each p1 value is held for exactly dwell cycles; the step occurs on the edge where the dwell count expires.
REQ-021 UP step: sum = p1 + p_step, computed P_W+1 bits wide; if sum >= p_stop, p1 = p_stop (clamp); otherwise p1 = sum.
REQ-022 DOWN step: if p1 < p_start + p_step (P_W+1 bits wide), p1 = p_start (clamp); otherwise p1 = p1 - p_step.
REQ-023 When p1 == p_stop and its dwell expires in UP:
  - mode 00: go to FINISH.
  - mode 01: p1 = p_start, stay in UP.
  - mode 10: go to DOWN and take a DOWN step.
REQ-024 When p1 == p_start and its dwell expires in DOWN: go to UP and take an UP step.
REQ-025 If the latched p_stop <= p_start, p1 = p_start for one dwell period, then FINISH, regardless of mode.
REQ-026 FINISH lasts one cycle: done=1, busy=0; next state is IDLE.
REQ-027 p1 holds its value in IDLE and FINISH.
REQ-028 abort=1 in UP or DOWN: next cycle state=IDLE, busy=0, no done pulse, no step_strobe, p1 holds its current value.
REQ-029 abort and start asserted together: abort wins and the sweep does not start.
REQ-030 start while busy=1 is ignored.
REQ-031 step_strobe=1 on every edge where p1 is loaded with a new step, including wrap loads and clamp loads, even if the value is numerically unchanged.

Reset
REQ-032 reset=0 forces, asynchronously: state=IDLE, p1=0, busy=0, step_strobe=0, done=0, dwell counter=0, latched configuration=0.
REQ-033 reset asserted mid-sweep aborts the sweep with no done pulse; after release the block waits in IDLE for start.

Verification
REQ-034 Single sweep: p_start=13, p_stop=88, p_step=25, dwell=4, mode=00, start at cycle 0 -> p1 = 13 (cycles 1-4), 38 (5-8), 63 (9-12), 88 (13-16); done=1 and busy=0 at cycle 17; p1 stays 88 afterwards.
REQ-035 Clamp, sawtooth: p_start=13, p_stop=50, p_step=25, dwell=2, mode=01 -> p1 sequence 13, 38, 50, 13, 38, ..., each value held 2 cycles; done never asserts.
REQ-036 Triangle: same values as REQ-035 with mode=10 -> p1 sequence 13, 38, 50, 25, 13, 38, 50, ...; the drop 25-25 clamps to 13.
REQ-037 Abort: abort while p1=38 in REQ-034 -> busy=0 the next cycle, done stays 0, p1 holds 38; a new start is accepted one cycle later.
REQ-038 Degenerate and edge cases: p_stop=p_start=47 with dwell=0 -> p1=47 for 1 cycle, then a done pulse; reset pulled low mid-sweep -> p1=0 and busy=0 immediately, without waiting for a clock edge.
